// File: rtl/dbus_pkg.sv
// ---------------------------------------------------------------------------
// dbus_pkg
// Shared definitions for the data-bus responder: bus widths, write-response
// codes, the read/write FSM state encodings, the value returned for
// out-of-range reads, the stall-LFSR seed, and small helper functions.
// No ports (package).
// ---------------------------------------------------------------------------
package dbus_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  // Write response codes as seen on dw_resp
  localparam logic RESP_OK  = 1'b1;
  localparam logic RESP_ERR = 1'b0;

  // Data returned for a read whose address lies outside the memory
  localparam logic [DATA_WIDTH-1:0] RD_ERR_DATA = 32'hDEADBEEF;

  // Seed of the optional ready-stall LFSR
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  // An address is in range when every bit above the word index is zero.
  // Bits [1:0] are the byte offset and never affect the result.
  function automatic logic addrInRange(input logic [31:0] addr,
                                       input int          wordsLog2);
    return ((addr >> (wordsLog2 + 2)) == 32'd0);
  endfunction

  // 8-bit Fibonacci LFSR step, taps 8,6,5,4 (bits 7,5,4,3), shifting left.
  function automatic logic [7:0] lfsrNext(input logic [7:0] state);
    return {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
  endfunction

endpackage

// File: rtl/dbus_mem.sv
// ---------------------------------------------------------------------------
// dbus_mem
// Word-organised memory with one byte-strobed write port and one
// combinational read port. Contents are never initialised or reset, so a
// reset of the surrounding logic leaves stored data intact.
//
// Ports:
//   clk        clock for the write port
//   wr_en_i    commit a write this edge
//   wr_addr_i  word index of the write
//   wr_data_i  write data
//   wr_strb_i  byte enables, bit i covers data bits 8i+7:8i
//   rd_addr_i  word index of the read
//   rd_data_o  read data, combinational from rd_addr_i
// ---------------------------------------------------------------------------
module dbus_mem
  import dbus_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 10
) (
  input  logic                       clk,
  input  logic                       wr_en_i,
  input  logic [ADDR_WORDS_LOG2-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  input  logic [STRB_WIDTH-1:0]      wr_strb_i,
  input  logic [ADDR_WORDS_LOG2-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_WORDS_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-lane write: only lanes whose strobe is set are touched, the others
  // keep their previous contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb_i[b]) begin
          mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  // The read port is combinational so the responder can capture the word
  // in the same edge that accepts the read address.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/dbus_responder.sv
// ---------------------------------------------------------------------------
// dbus_responder
// Memory-backed responder for a valid/ready data bus with an independent
// read channel (address + data) and write channel (data/address + response).
// Each channel is a small FSM; a shared arbiter lets at most one request in
// per cycle, with writes winning a tie so a simultaneous read sees the new
// data.
//
// Parameters:
//   ADDR_WORDS_LOG2  memory depth is 2**ADDR_WORDS_LOG2 32-bit words
//   RD_LATENCY       cycles from read-address accept to dr_data_valid (0..7)
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   dr_addr_valid/ready, dr_addr   read-address channel
//   dr_data_valid/ready, dr_data   read-data channel
//   dw_data_addr_valid/ready,      write channel
//     dw_data, dw_addr, dw_strobe
//   dw_resp_valid/ready, dw_resp   write response, 1 = OK, 0 = out of range
//
// Build option:
//   DBUS_RESPONDER_STALL_EN  when defined, both address-channel readies are
//                            gated by bit 0 of a free-running 8-bit LFSR to
//                            exercise requester back-pressure handling.
// ---------------------------------------------------------------------------
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int RD_LATENCY      = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  dr_addr_valid,
  output logic                  dr_addr_ready,
  input  logic [31:0]           dr_addr,

  output logic                  dr_data_valid,
  input  logic                  dr_data_ready,
  output logic [DATA_WIDTH-1:0] dr_data,

  input  logic                  dw_data_addr_valid,
  output logic                  dw_data_addr_ready,
  input  logic [DATA_WIDTH-1:0] dw_data,
  input  logic [31:0]           dw_addr,
  input  logic [STRB_WIDTH-1:0] dw_strobe,

  output logic                  dw_resp_valid,
  input  logic                  dw_resp_ready,
  output logic                  dw_resp
);

  // With zero read latency a channel may accept its next request in the
  // same cycle its response handshakes; otherwise it passes through IDLE.
  localparam logic BACK_TO_BACK = (RD_LATENCY == 0);

  // Final count value of the WAIT state; unused when RD_LATENCY is 0.
  localparam logic [2:0] LAST_COUNT =
    (RD_LATENCY == 0) ? 3'd0 : 3'(RD_LATENCY - 1);

  rd_state_e             rdState_q, rdState_d;
  wr_state_e             wrState_q, wrState_d;
  logic [2:0]            latCnt_q, latCnt_d;
  logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
  logic                  wrResp_q, wrResp_d;

  logic                  stallOk;
  logic                  rdCanAccept;
  logic                  wrCanAccept;
  logic                  rdReady;
  logic                  wrReady;
  logic                  rdAccept;
  logic                  wrAccept;
  logic                  rdInRange;
  logic                  wrInRange;
  logic [DATA_WIDTH-1:0] memRdData;

  // -------------------------------------------------------------------------
  // Optional ready stall
  // -------------------------------------------------------------------------
`ifdef DBUS_RESPONDER_STALL_EN
  logic [7:0] lfsr_q;

  // Free-running LFSR; its bit 0 decides whether the address channels may
  // accept in the current cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsrNext(lfsr_q);
    end
  end

  assign stallOk = lfsr_q[0];
`else
  assign stallOk = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  assign rdInRange = addrInRange(dr_addr, ADDR_WORDS_LOG2);
  assign wrInRange = addrInRange(dw_addr, ADDR_WORDS_LOG2);

  // -------------------------------------------------------------------------
  // Arbitration and handshakes
  // -------------------------------------------------------------------------
  // Readies depend only on state, the opposite channel's request and the
  // stall term, never on the same channel's valid. A write that is actually
  // going to be accepted blocks the read for that cycle.
  always_comb begin
    rdCanAccept = (rdState_q == RD_IDLE) ||
                  (BACK_TO_BACK && (rdState_q == RD_RESP) && dr_data_ready);
    wrCanAccept = (wrState_q == WR_IDLE) ||
                  (BACK_TO_BACK && (wrState_q == WR_RESP) && dw_resp_ready);
    wrReady     = wrCanAccept && stallOk;
    rdReady     = rdCanAccept && stallOk && !(wrReady && dw_data_addr_valid);
  end

  assign rdAccept = dr_addr_valid && rdReady;
  assign wrAccept = dw_data_addr_valid && wrReady;

  // -------------------------------------------------------------------------
  // Memory
  // -------------------------------------------------------------------------
  dbus_mem #(
    .ADDR_WORDS_LOG2 (ADDR_WORDS_LOG2)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wrAccept && wrInRange),
    .wr_addr_i (dw_addr[ADDR_WORDS_LOG2+1:2]),
    .wr_data_i (dw_data),
    .wr_strb_i (dw_strobe),
    .rd_addr_i (dr_addr[ADDR_WORDS_LOG2+1:2]),
    .rd_data_o (memRdData)
  );

  // -------------------------------------------------------------------------
  // FSM state registers
  // -------------------------------------------------------------------------
  // Both channel FSMs and the latency counter; reset drops any pending
  // response immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdState_q <= RD_IDLE;
      wrState_q <= WR_IDLE;
      latCnt_q  <= 3'd0;
    end else begin
      rdState_q <= rdState_d;
      wrState_q <= wrState_d;
      latCnt_q  <= latCnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read FSM next state
  // -------------------------------------------------------------------------
  // The counter is cleared on entering WAIT and again on leaving it, so it
  // reads zero whenever the FSM is outside WAIT.
  always_comb begin
    rdState_d = rdState_q;
    latCnt_d  = latCnt_q;
    case (rdState_q)
      RD_IDLE: begin
        if (rdAccept) begin
          latCnt_d  = 3'd0;
          rdState_d = BACK_TO_BACK ? RD_RESP : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (latCnt_q == LAST_COUNT) begin
          latCnt_d  = 3'd0;
          rdState_d = RD_RESP;
        end else begin
          latCnt_d  = latCnt_q + 3'd1;
        end
      end
      RD_RESP: begin
        if (dr_data_ready) begin
          rdState_d = rdAccept ? RD_RESP : RD_IDLE;
        end
      end
      default: begin
        latCnt_d  = 3'd0;
        rdState_d = RD_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Write FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    wrState_d = wrState_q;
    case (wrState_q)
      WR_IDLE: begin
        if (wrAccept) begin
          wrState_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (dw_resp_ready) begin
          wrState_d = wrAccept ? WR_RESP : WR_IDLE;
        end
      end
      default: begin
        wrState_d = WR_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Response payload registers
  // -------------------------------------------------------------------------
  // Read data is captured at the accept edge and held until the next accept,
  // which keeps dr_data stable for the whole RESP phase.
  always_comb begin
    rdData_d = rdData_q;
    wrResp_d = wrResp_q;
    if (rdAccept) begin
      rdData_d = rdInRange ? memRdData : RD_ERR_DATA;
    end
    if (wrAccept) begin
      wrResp_d = wrInRange ? RESP_OK : RESP_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdData_q <= '0;
      wrResp_q <= 1'b0;
    end else begin
      rdData_q <= rdData_d;
      wrResp_q <= wrResp_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    dr_addr_ready      = rdReady;
    dw_data_addr_ready = wrReady;
    dr_data_valid      = (rdState_q == RD_RESP);
    dw_resp_valid      = (wrState_q == WR_RESP);
    dr_data            = rdData_q;
    dw_resp            = wrResp_q;
  end

endmodule

// File: tb/tb_dbus_responder.sv
// ---------------------------------------------------------------------------
// tb_dbus_responder
// Directed bench for dbus_responder in its default build (stall disabled,
// RD_LATENCY = 1, 1024-word memory). Inputs change on the falling edge and
// outputs are sampled there or just after, away from the active edge.
// ---------------------------------------------------------------------------
module tb_dbus_responder;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        dr_addr_valid;
  logic        dr_addr_ready;
  logic [31:0] dr_addr;
  logic        dr_data_valid;
  logic        dr_data_ready;
  logic [31:0] dr_data;
  logic        dw_data_addr_valid;
  logic        dw_data_addr_ready;
  logic [31:0] dw_data;
  logic [31:0] dw_addr;
  logic [3:0]  dw_strobe;
  logic        dw_resp_valid;
  logic        dw_resp_ready;
  logic        dw_resp;

  int checkCount = 0;
  int errorCount = 0;

  dbus_responder #(
    .ADDR_WORDS_LOG2 (10),
    .RD_LATENCY      (RD_LAT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .dr_addr_valid      (dr_addr_valid),
    .dr_addr_ready      (dr_addr_ready),
    .dr_addr            (dr_addr),
    .dr_data_valid      (dr_data_valid),
    .dr_data_ready      (dr_data_ready),
    .dr_data            (dr_data),
    .dw_data_addr_valid (dw_data_addr_valid),
    .dw_data_addr_ready (dw_data_addr_ready),
    .dw_data            (dw_data),
    .dw_addr            (dw_addr),
    .dw_strobe          (dw_strobe),
    .dw_resp_valid      (dw_resp_valid),
    .dw_resp_ready      (dw_resp_ready),
    .dw_resp            (dw_resp)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive every requester-side input in one go
  task automatic applyStimulus(input logic rdV, input logic [31:0] rdA,
                               input logic rdR, input logic wrV,
                               input logic [31:0] wrA, input logic [31:0] wrD,
                               input logic [3:0] wrS, input logic respR);
    dr_addr_valid      = rdV;
    dr_addr            = rdA;
    dr_data_ready      = rdR;
    dw_data_addr_valid = wrV;
    dw_addr            = wrA;
    dw_data            = wrD;
    dw_strobe          = wrS;
    dw_resp_ready      = respR;
  endtask

  // Single write transaction including its response handshake
  task automatic writeWord(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic expResp);
    @(negedge clk);
    dw_data_addr_valid = 1'b1;
    dw_addr            = addr;
    dw_data            = data;
    dw_strobe          = strb;
    #1;
    checkOutput({tag, ".wready"}, 32'(dw_data_addr_ready), 32'd1);
    @(negedge clk);
    dw_data_addr_valid = 1'b0;
    checkOutput({tag, ".respvalid"}, 32'(dw_resp_valid), 32'd1);
    checkOutput({tag, ".resp"}, 32'(dw_resp), 32'(expResp));
    dw_resp_ready = 1'b1;
    @(negedge clk);
    dw_resp_ready = 1'b0;
    checkOutput({tag, ".respdone"}, 32'(dw_resp_valid), 32'd0);
  endtask

  // Single read transaction; measures accept-to-valid latency
  task automatic readWord(input string tag, input logic [31:0] addr,
                          input logic [31:0] expData);
    int lat;
    @(negedge clk);
    dr_addr_valid = 1'b1;
    dr_addr       = addr;
    #1;
    checkOutput({tag, ".aready"}, 32'(dr_addr_ready), 32'd1);
    @(negedge clk);
    dr_addr_valid = 1'b0;
    lat = 0;
    while (!dr_data_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(RD_LAT));
    checkOutput({tag, ".data"}, dr_data, expData);
    dr_data_ready = 1'b1;
    @(negedge clk);
    dr_data_ready = 1'b0;
    checkOutput({tag, ".validdrop"}, 32'(dr_data_valid), 32'd0);
  endtask

  // Hard stop in case the run wanders off
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst.dvalid", 32'(dr_data_valid), 32'd0);
    checkOutput("rst.respvalid", 32'(dw_resp_valid), 32'd0);
    checkOutput("rst.ddata", dr_data, 32'h0);
    checkOutput("rst.resp", 32'(dw_resp), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle.aready", 32'(dr_addr_ready), 32'd1);
    checkOutput("idle.wready", 32'(dw_data_addr_ready), 32'd1);

    // Known contents in word 0 for the out-of-range alias check later
    $display("[TB] basic write/read");
    writeWord("w0", 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b1);
    writeWord("w10", 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b1);
    readWord("r10", 32'h0000_0010, 32'h1234_5678);

    // Partial strobe over existing data, low address bits ignored
    $display("[TB] byte strobes");
    writeWord("w10s", 32'h0000_0012, 32'hAABB_CCDD, 4'b0101, 1'b1);
    readWord("r10s", 32'h0000_0011, 32'h12BB_56DD);

    // Out of range: 0x1000 would alias word 0 if the upper bits were ignored
    $display("[TB] out of range");
    writeWord("woor", 32'h0000_1000, 32'h1111_1111, 4'hF, 1'b0);
    readWord("roor", 32'h0000_1000, 32'hDEAD_BEEF);
    readWord("rw0", 32'h0000_0000, 32'hCAFE_F00D);

    // Simultaneous read and write to the same word
    $display("[TB] simultaneous read and write");
    @(negedge clk);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 32'h20, 32'h5A5A_A5A5, 4'hF, 1'b0);
    #1;
    checkOutput("both.areadylow", 32'(dr_addr_ready), 32'd0);
    checkOutput("both.wready", 32'(dw_data_addr_ready), 32'd1);
    @(negedge clk);
    dw_data_addr_valid = 1'b0;
    #1;
    checkOutput("both.respvalid", 32'(dw_resp_valid), 32'd1);
    checkOutput("both.resp", 32'(dw_resp), 32'd1);
    checkOutput("both.areadynext", 32'(dr_addr_ready), 32'd1);
    @(negedge clk);
    dr_addr_valid = 1'b0;
    dw_resp_ready = 1'b1;
    checkOutput("both.rwait", 32'(dr_data_valid), 32'd0);
    @(negedge clk);
    dw_resp_ready = 1'b0;
    checkOutput("both.dvalid", 32'(dr_data_valid), 32'd1);
    checkOutput("both.ddata", dr_data, 32'h5A5A_A5A5);
    checkOutput("both.respdone", 32'(dw_resp_valid), 32'd0);
    dr_data_ready = 1'b1;
    @(negedge clk);
    dr_data_ready = 1'b0;

    // Back-pressure on the read-data channel
    $display("[TB] read back-pressure");
    @(negedge clk);
    dr_addr_valid = 1'b1;
    dr_addr       = 32'h10;
    @(negedge clk);
    dr_addr_valid = 1'b0;
    lat = 0;
    while (!dr_data_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("hold.latency", 32'(lat), 32'(RD_LAT));
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold.dvalid", 32'(dr_data_valid), 32'd1);
      checkOutput("hold.ddata", dr_data, 32'h12BB_56DD);
      checkOutput("hold.areadylow", 32'(dr_addr_ready), 32'd0);
      @(negedge clk);
    end
    dr_data_ready = 1'b1;
    @(negedge clk);
    dr_data_ready = 1'b0;
    checkOutput("hold.validdrop", 32'(dr_data_valid), 32'd0);

    // Reset while the read sits in WAIT
    $display("[TB] reset during read wait");
    @(negedge clk);
    dr_addr_valid = 1'b1;
    dr_addr       = 32'h20;
    @(negedge clk);
    dr_addr_valid = 1'b0;
    checkOutput("rstw.inwait", 32'(dr_data_valid), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstw.dvalid", 32'(dr_data_valid), 32'd0);
    checkOutput("rstw.ddata", dr_data, 32'h0);
    checkOutput("rstw.resp", 32'(dw_resp), 32'd0);
    @(negedge clk);
    checkOutput("rstw.held", 32'(dr_data_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstw.aready", 32'(dr_addr_ready), 32'd1);
    checkOutput("rstw.novalid", 32'(dr_data_valid), 32'd0);
    readWord("rstw.mem", 32'h0000_0020, 32'h5A5A_A5A5);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter ADDR_WORDS_LOG2, default 10, giving the memory depth in 32-bit words.
REQ-002 SHALL have parameter RD_LATENCY, default 1, range 0..7, giving the cycles from read-address accept to dr_data_valid.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports dr_addr_valid (input, 1), dr_addr_ready (output, 1) and dr_addr (input, 32): the read-address channel.
REQ-006 SHALL have ports dr_data_valid (output, 1), dr_data_ready (input, 1) and dr_data (output, 32): the read-data channel.
REQ-007 SHALL have ports dw_data_addr_valid (input, 1), dw_data_addr_ready (output, 1), dw_data (input, 32), dw_addr (input, 32) and dw_strobe (input, 4): the write channel.
REQ-008 SHALL have ports dw_resp_valid (output, 1), dw_resp_ready (input, 1) and dw_resp (output, 1): the write response, where 1 means OK and 0 means out-of-range.

Function
REQ-009 SHALL transfer on any channel only in a cycle where valid and ready are both high at the clk rising edge.
REQ-010 SHALL index words by addr[ADDR_WORDS_LOG2+1:2], ignore addr[1:0], and treat any nonzero addr[31:ADDR_WORDS_LOG2+2] as out-of-range.
REQ-011 SHALL implement the read FSM as follows:
- IDLE: dr_addr_ready=1; accept -> WAIT, or -> RESP directly when RD_LATENCY=0.
- WAIT: count RD_LATENCY-1 further cycles, then -> RESP.
- RESP: dr_data_valid=1 with dr_data held stable until dr_data_ready, then -> IDLE.
REQ-012 SHALL capture read data at the accept edge; an out-of-range read SHALL return 32'hDEADBEEF.
REQ-013 SHALL implement the write FSM as follows:
- IDLE: dw_data_addr_ready=1; accept -> RESP, committing the write at that edge.
- RESP: dw_resp_valid=1 with dw_resp held stable until dw_resp_ready, then -> IDLE.
REQ-014 SHALL write only the bytes whose dw_strobe bit is set (strobe[i] -> bits 8i+7:8i); an out-of-range write SHALL not modify memory and SHALL give dw_resp=0.
REQ-015 SHALL accept at most one request per cycle; if both channels are offered together with both FSMs idle, the write is accepted, dr_addr_ready is low that cycle, and the read is accepted the next cycle and returns the post-write data.
REQ-016 SHALL drive every ready output combinationally only from FSM state, the arbitration of REQ-015, and the stall term of REQ-020; no ready output SHALL depend on the same channel's valid.
REQ-017 SHALL let a new accept on a channel occur in the same cycle its previous response handshakes only when RD_LATENCY=0; otherwise that channel returns to IDLE first.

Reset
REQ-018 SHALL, while rst is high, force both FSMs to IDLE, the latency counter to 0, dr_data_valid=0, dw_resp_valid=0, dr_data=0 and dw_resp=0.
REQ-019 SHALL, on reset asserted mid-transaction, drop any pending response without retry and leave memory contents unchanged (no initialization).

Configuration
REQ-020 SHALL, when DBUS_RESPONDER_STALL_EN is defined, AND both address-channel readies with bit 0 of an 8-bit Fibonacci LFSR (taps 8,6,5,4, reset seed 8'hA5) that advances every cycle; when the macro is undefined, no stall logic SHALL exist and readies follow REQ-011/REQ-013/REQ-015 only.

Structure
REQ-021 SHALL place DATA_WIDTH=32, STRB_WIDTH=4, the RESP_OK/RESP_ERR constants, the read/write FSM state enums and the LFSR seed in the shared package dbus_pkg.
REQ-022 SHALL instantiate the memory array as one sub-module, dbus_mem (1 write port with byte strobes, 1 read port, 2**ADDR_WORDS_LOG2 words).

Verification
REQ-023 SHALL cover these directed scenarios, each stimulus -> required response:
- Write 0x12345678 to 0x10 with strobe 4'hF, then read 0x10 -> dw_resp=1; dr_data=0x12345678 exactly RD_LATENCY cycles after the read accept.
- Write 0xAABBCCDD to 0x10 with strobe 4'b0101 over prior 0x12345678 -> read returns 0x12BB56DD.
- Write to 0x0000_1000 with default depth -> dw_resp=0; a read of 0x1000 returns 0xDEADBEEF; word 0 unchanged.
- Read and write to 0x20 offered in the same cycle -> write accepted first, read accepted next cycle, read returns the new data.
- Hold dr_data_ready low 5 cycles during RESP -> dr_data_valid and dr_data stable throughout; dr_addr_ready stays 0.
- Assert rst during WAIT -> dr_data_valid=0 immediately; after release, dr_addr_ready=1 next cycle (macro undefined).
